// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tpu_pkg
// Description : Shared types and constants for the systolic tile controller.
// Revision    : 1.0 - initial release
// ============================================================================
package tpu_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } sys_ctrl_state_e;

    localparam int C_DEF_K_MAX      = 256;
    localparam int C_DEF_K_WIDTH    = $clog2(C_DEF_K_MAX + 1);
    localparam int C_DEF_ADDR_WIDTH = $clog2(C_DEF_K_MAX);

    // Cycles from the last operand read until every accumulator has settled:
    // buffer latency, worst-case lane skew on both edges, then the PE update.
    function automatic int drain_cycles(input int rd_lat, input int height,
                                        input int width, input int pe_lat);
        return rd_lat + (height - 1) + (width - 1) + pe_lat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/skew_line.sv
`default_nettype none
// ============================================================================
// Module      : skew_line
// Description : DEPTH-stage data+valid delay line feeding one array lane.
//               Output is forced to zero whenever the delayed valid is low.
//               DEPTH=0 is a gated passthrough.
// Revision    : 1.0 - initial release
// ============================================================================
module skew_line #(
    parameter int DW    = 32,
    parameter int DEPTH = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] i_data,
    input  logic          i_valid,
    output logic [DW-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_pass
            // Lane 0 needs no delay, so the clock and reset go unused here.
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = clk ^ rst;
            assign o_data = i_valid ? i_data : '0;
        end else begin : g_shift
            logic [DW-1:0]    r_data [DEPTH];
            logic [DEPTH-1:0] r_valid;

            // Shift data and valid together; empty slots hold zero.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_valid <= '0;
                    for (int s = 0; s < DEPTH; s++) begin
                        r_data[s] <= '0;
                    end
                end else begin
                    r_valid[0] <= i_valid;
                    r_data[0]  <= i_valid ? i_data : '0;
                    for (int s = 1; s < DEPTH; s++) begin
                        r_valid[s] <= r_valid[s-1];
                        r_data[s]  <= r_data[s-1];
                    end
                end
            end

            assign o_data = r_valid[DEPTH-1] ? r_data[DEPTH-1] : '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/systolic_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : systolic_ctrl
// Description : Sequencer for one output-stationary systolic matmul tile.
//               Clears the array, reads K operand columns/rows, skews them
//               diagonally onto the array edges, waits out the pipeline and
//               holds result-valid until the consumer acknowledges.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_ctrl
    import tpu_pkg::*;
#(
    parameter  int DATA_WIDTH   = 32,
    parameter  int ARRAY_WIDTH  = 4,
    parameter  int ARRAY_HEIGHT = 4,
    parameter  int K_MAX        = C_DEF_K_MAX,
    parameter  int RD_LAT       = 1,
    parameter  int PE_LAT       = 1,
    localparam int C_ADDR_WIDTH = $clog2(K_MAX),
    localparam int C_K_WIDTH    = $clog2(K_MAX + 1)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               start_i,
    input  logic [C_K_WIDTH-1:0]               k_len_i,
    output logic                               ready_o,
    output logic                               busy_o,
    output logic                               result_vld_o,
    input  logic                               result_ack_i,
    output logic                               act_rd_en_o,
    output logic [C_ADDR_WIDTH-1:0]            act_rd_addr_o,
    input  logic [ARRAY_HEIGHT*DATA_WIDTH-1:0] act_rd_data_i,
    output logic                               wgt_rd_en_o,
    output logic [C_ADDR_WIDTH-1:0]            wgt_rd_addr_o,
    input  logic [ARRAY_WIDTH*DATA_WIDTH-1:0]  wgt_rd_data_i,
    output logic                               arr_clear_o,
    output logic [ARRAY_HEIGHT*DATA_WIDTH-1:0] arr_active_o,
    output logic [ARRAY_WIDTH*DATA_WIDTH-1:0]  arr_weight_o
);

    localparam int C_DRAIN  = drain_cycles(RD_LAT, ARRAY_HEIGHT, ARRAY_WIDTH, PE_LAT);
    localparam int C_DCNT_W = $clog2(C_DRAIN + 1);

    sys_ctrl_state_e         r_state;
    sys_ctrl_state_e         w_next;
    logic [C_K_WIDTH-1:0]    r_k_len;
    logic [C_ADDR_WIDTH-1:0] r_k_cnt;
    logic [C_DCNT_W-1:0]     r_drain_cnt;
    logic [RD_LAT-1:0]       r_rd_vld;
    logic                    w_k_last;
    logic                    w_drain_last;
    logic                    w_rd_en;
    logic                    w_data_vld;

    // Compare in K width so K=K_MAX terminates at address K_MAX-1 without wrapping.
    assign w_k_last     = (C_K_WIDTH'(r_k_cnt) + C_K_WIDTH'(1)) == r_k_len;
    assign w_drain_last = r_drain_cnt == C_DCNT_W'(C_DRAIN - 1);
    assign w_data_vld   = r_rd_vld[RD_LAT-1];

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and state-decoded control outputs.
    always_comb begin
        w_next       = r_state;
        ready_o      = 1'b0;
        busy_o       = 1'b0;
        result_vld_o = 1'b0;
        arr_clear_o  = 1'b0;
        w_rd_en      = 1'b0;
        case (r_state)
            IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    w_next = CLEAR;
                end
            end
            CLEAR: begin
                busy_o      = 1'b1;
                arr_clear_o = 1'b1;
                w_next      = (r_k_len == '0) ? DRAIN : STREAM;
            end
            STREAM: begin
                busy_o  = 1'b1;
                w_rd_en = 1'b1;
                if (w_k_last) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                busy_o = 1'b1;
                if (w_drain_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                result_vld_o = 1'b1;
                if (result_ack_i) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Inner-step counter, latched K and drain counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_k_len     <= '0;
            r_k_cnt     <= '0;
            r_drain_cnt <= '0;
        end else begin
            if (r_state == IDLE && start_i) begin
                r_k_len <= k_len_i;
                r_k_cnt <= '0;
            end else if (r_state == STREAM && !w_k_last) begin
                r_k_cnt <= r_k_cnt + C_ADDR_WIDTH'(1);
            end
            if (r_state == DRAIN) begin
                r_drain_cnt <= r_drain_cnt + C_DCNT_W'(1);
            end else begin
                r_drain_cnt <= '0;
            end
        end
    end

    // Read strobe delayed by the buffer latency marks when read data is valid.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_vld <= '0;
        end else begin
            r_rd_vld <= (r_rd_vld << 1) | RD_LAT'(w_rd_en);
        end
    end

    assign act_rd_en_o   = w_rd_en;
    assign wgt_rd_en_o   = w_rd_en;
    assign act_rd_addr_o = w_rd_en ? r_k_cnt : '0;
    assign wgt_rd_addr_o = w_rd_en ? r_k_cnt : '0;

    // Activation row i enters the array i cycles late.
    generate
        for (genvar i = 0; i < ARRAY_HEIGHT; i++) begin : g_act_lane
            skew_line #(
                .DW    (DATA_WIDTH),
                .DEPTH (i)
            ) u_skew (
                .clk     (clk_i),
                .rst     (rst_i),
                .i_data  (act_rd_data_i[i*DATA_WIDTH +: DATA_WIDTH]),
                .i_valid (w_data_vld),
                .o_data  (arr_active_o[i*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

    // Weight column j enters the array j cycles late.
    generate
        for (genvar j = 0; j < ARRAY_WIDTH; j++) begin : g_wgt_lane
            skew_line #(
                .DW    (DATA_WIDTH),
                .DEPTH (j)
            ) u_skew (
                .clk     (clk_i),
                .rst     (rst_i),
                .i_data  (wgt_rd_data_i[j*DATA_WIDTH +: DATA_WIDTH]),
                .i_valid (w_data_vld),
                .o_data  (arr_weight_o[j*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_systolic_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_ctrl
// Description : Directed bench for systolic_ctrl with 1-cycle operand buffers
//               and a behavioural 4x4 output-stationary array.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_ctrl;

    localparam int DW = 32;
    localparam int H  = 4;
    localparam int W  = 4;
    localparam int KM = 256;
    localparam int KW = 9;
    localparam int D  = 8;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            start_i;
    logic [KW-1:0]   k_len_i;
    logic            ready_o, busy_o, result_vld_o, result_ack_i;
    logic            act_rd_en_o, wgt_rd_en_o, arr_clear_o;
    logic [7:0]      act_rd_addr_o, wgt_rd_addr_o;
    logic [H*DW-1:0] act_rd_data_i = '0;
    logic [W*DW-1:0] wgt_rd_data_i = '0;
    logic [H*DW-1:0] arr_active_o;
    logic [W*DW-1:0] arr_weight_o;

    systolic_ctrl dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .k_len_i       (k_len_i),
        .ready_o       (ready_o),
        .busy_o        (busy_o),
        .result_vld_o  (result_vld_o),
        .result_ack_i  (result_ack_i),
        .act_rd_en_o   (act_rd_en_o),
        .act_rd_addr_o (act_rd_addr_o),
        .act_rd_data_i (act_rd_data_i),
        .wgt_rd_en_o   (wgt_rd_en_o),
        .wgt_rd_addr_o (wgt_rd_addr_o),
        .wgt_rd_data_i (wgt_rd_data_i),
        .arr_clear_o   (arr_clear_o),
        .arr_active_o  (arr_active_o),
        .arr_weight_o  (arr_weight_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_err = 0;

    logic [DW-1:0] mat_a [H][KM];
    logic [DW-1:0] mat_b [KM][W];
    logic [DW-1:0] exp_c [H][W];

    // Operand buffers: one-cycle registered read.
    always @(posedge clk_i) begin
        if (act_rd_en_o)
            for (int i = 0; i < H; i++) act_rd_data_i[i*DW +: DW] <= mat_a[i][act_rd_addr_o];
        if (wgt_rd_en_o)
            for (int j = 0; j < W; j++) wgt_rd_data_i[j*DW +: DW] <= mat_b[wgt_rd_addr_o][j];
    end

    // Behavioural array: activations move right, weights move down.
    logic [DW-1:0] pe_a [H][W];
    logic [DW-1:0] pe_w [H][W];
    logic [DW-1:0] a_reg [H][W];
    logic [DW-1:0] w_reg [H][W];
    logic [DW-1:0] acc [H][W];

    always_comb begin
        for (int i = 0; i < H; i++)
            for (int j = 0; j < W; j++) begin
                pe_a[i][j] = (j == 0) ? arr_active_o[i*DW +: DW] : a_reg[i][j];
                pe_w[i][j] = (i == 0) ? arr_weight_o[j*DW +: DW] : w_reg[i][j];
            end
    end

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < H; i++)
                for (int j = 0; j < W; j++) begin
                    a_reg[i][j] <= '0; w_reg[i][j] <= '0; acc[i][j] <= '0;
                end
        end else begin
            for (int i = 0; i < H; i++)
                for (int j = 0; j < W; j++) begin
                    if (j > 0) a_reg[i][j] <= pe_a[i][j-1];
                    if (i > 0) w_reg[i][j] <= pe_w[i-1][j];
                    acc[i][j] <= arr_clear_o ? '0 : acc[i][j] + pe_a[i][j] * pe_w[i][j];
                end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load_const(input logic [DW-1:0] av, input logic [DW-1:0] bv, input int K);
        for (int k = 0; k < KM; k++) begin
            for (int i = 0; i < H; i++) mat_a[i][k] = av;
            for (int j = 0; j < W; j++) mat_b[k][j] = bv;
        end
        for (int i = 0; i < H; i++)
            for (int j = 0; j < W; j++) exp_c[i][j] = av * bv * K;
    endtask

    task automatic golden(input int K);
        for (int i = 0; i < H; i++)
            for (int j = 0; j < W; j++) begin
                exp_c[i][j] = '0;
                for (int k = 0; k < K; k++) exp_c[i][j] = exp_c[i][j] + mat_a[i][k] * mat_b[k][j];
            end
    endtask

    task automatic check_results(input string tag);
        for (int i = 0; i < H; i++)
            for (int j = 0; j < W; j++)
                check($sformatf("%s_c%0d%0d", tag, i, j), acc[i][j], exp_c[i][j]);
    endtask

    int t_lat, t_nrd, t_addr_bad, t_clr, t_clr_bad, t_busy_bad;
    int t_first_w [W];

    // Accept a tile and watch it until result_vld_o; e counts edges after accept.
    task automatic run_tile(input int K, input bit pulse);
        int e;
        t_lat = -1; t_nrd = 0; t_addr_bad = 0; t_clr = 0; t_clr_bad = 0; t_busy_bad = 0;
        for (int j = 0; j < W; j++) t_first_w[j] = -1;
        k_len_i = KW'(K);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        e = 0;
        while (e < K + 40) begin
            if (act_rd_en_o || wgt_rd_en_o) begin
                if (!(act_rd_en_o && wgt_rd_en_o && int'(act_rd_addr_o) == t_nrd
                      && int'(wgt_rd_addr_o) == t_nrd)) t_addr_bad++;
                t_nrd++;
            end
            if (arr_clear_o) begin
                t_clr++;
                if (arr_active_o != '0 || arr_weight_o != '0) t_clr_bad++;
            end
            for (int j = 0; j < W; j++)
                if (t_first_w[j] < 0 && arr_weight_o[j*DW +: DW] != '0) t_first_w[j] = e;
            if (result_vld_o) begin
                t_lat = e;
                break;
            end
            if (!busy_o || ready_o) t_busy_bad++;
            start_i = pulse && (e == 2 || e == K + 4);
            @(negedge clk_i);
            e++;
        end
        start_i = 1'b0;
    endtask

    task automatic tile_checks(input string tag, input int K);
        check({tag, "_latency"}, t_lat, 1 + K + D);
        check({tag, "_rd_count"}, t_nrd, K);
        check({tag, "_addr_seq"}, t_addr_bad, 0);
        check({tag, "_clear_cycles"}, t_clr, 1);
        check({tag, "_clear_lanes_zero"}, t_clr_bad, 0);
        check({tag, "_busy"}, t_busy_bad, 0);
    endtask

    task automatic ack_tile(input string tag);
        check({tag, "_vld"}, result_vld_o, 1);
        result_ack_i = 1'b1;
        @(negedge clk_i);
        result_ack_i = 1'b0;
        check({tag, "_ready_after_ack"}, ready_o, 1);
        check({tag, "_vld_after_ack"}, result_vld_o, 0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ready"}, ready_o, 1);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_vld"}, result_vld_o, 0);
        check({tag, "_rd_en"}, {act_rd_en_o, wgt_rd_en_o}, 0);
        check({tag, "_addr"}, {act_rd_addr_o, wgt_rd_addr_o}, 0);
        check({tag, "_clear"}, arr_clear_o, 0);
        check({tag, "_act_lanes"}, (arr_active_o != '0), 0);
        check({tag, "_wgt_lanes"}, (arr_weight_o != '0), 0);
    endtask

    initial begin
        int c;
        rst_i = 1'b1; start_i = 1'b0; result_ack_i = 1'b0; k_len_i = '0;
        load_const(0, 0, 0);
        repeat (3) @(negedge clk_i);
        check_quiet("reset");
        rst_i = 1'b0;
        @(negedge clk_i);
        check("post_reset_ready", ready_o, 1);

        // 1: K=3, A=1, B=2 -> every result 6
        load_const(1, 2, 3);
        for (int i = 0; i < H; i++) for (int j = 0; j < W; j++) exp_c[i][j] = 32'd6;
        run_tile(3, 1'b0);
        tile_checks("t1", 3);
        check_results("t1");
        ack_tile("t1");

        // 2: K=4, A=identity, B[k][j]=4k+j+1 -> C=B; weight lane j first live j cycles late
        for (int k = 0; k < KM; k++) begin
            for (int i = 0; i < H; i++) mat_a[i][k] = (i == k) ? 32'd1 : 32'd0;
            for (int j = 0; j < W; j++) mat_b[k][j] = 4 * k + j + 1;
        end
        for (int i = 0; i < H; i++) for (int j = 0; j < W; j++) exp_c[i][j] = 4 * i + j + 1;
        run_tile(4, 1'b0);
        tile_checks("t2", 4);
        for (int j = 0; j < W; j++) check($sformatf("t2_skew_w%0d", j), t_first_w[j], 2 + j);
        check_results("t2");
        ack_tile("t2");

        // 3: K=0 with ack held high throughout -> zeros, done at 9, ack in first DONE cycle
        load_const(5, 7, 0);
        result_ack_i = 1'b1;
        run_tile(0, 1'b0);
        tile_checks("t3", 0);
        check_results("t3");
        @(negedge clk_i);
        result_ack_i = 1'b0;
        check("t3_ready_after_ack", ready_o, 1);
        check("t3_vld_after_ack", result_vld_o, 0);

        // 4: stray starts during STREAM/DRAIN, ack delayed 5 cycles with start held
        load_const(3, 1, 4);
        run_tile(4, 1'b1);
        tile_checks("t4", 4);
        check_results("t4");
        start_i = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk_i);
            check($sformatf("t4_hold_vld_%0d", n), result_vld_o, 1);
            check($sformatf("t4_hold_ready_%0d", n), ready_o, 0);
        end
        result_ack_i = 1'b1;
        @(negedge clk_i);
        result_ack_i = 1'b0;
        check("t4_idle_after_ack", ready_o, 1);
        check("t4_vld_after_ack", result_vld_o, 0);
        load_const(2, 5, 2);
        run_tile(2, 1'b0);
        tile_checks("t4b", 2);
        check_results("t4b");
        ack_tile("t4b");

        // 5: reset at k=2 of an 8-step tile, then a fresh K=2 tile
        load_const(9, 9, 8);
        k_len_i = KW'(8);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        c = 0;
        while (!(act_rd_en_o && act_rd_addr_o == 8'd2) && c < 10) begin
            @(negedge clk_i);
            c++;
        end
        check("t5_reached_k2", (act_rd_en_o && act_rd_addr_o == 8'd2), 1);
        rst_i = 1'b1;
        @(negedge clk_i);
        check_quiet("t5_abort");
        rst_i = 1'b0;
        @(negedge clk_i);
        load_const(3, 4, 2);
        run_tile(2, 1'b0);
        tile_checks("t5", 2);
        check_results("t5");
        ack_tile("t5");

        // 6: K=K_MAX with random operands
        for (int k = 0; k < KM; k++) begin
            for (int i = 0; i < H; i++) mat_a[i][k] = $urandom;
            for (int j = 0; j < W; j++) mat_b[k][j] = $urandom;
        end
        golden(KM);
        run_tile(KM, 1'b0);
        tile_checks("t6", KM);
        check_results("t6");
        ack_tile("t6");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
